rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single synchronous write port of the 2r1w integer register file among N writeback requesters (e.g. ALU, MUL, LSU).
- Arbitrates round-robin over valid/ready handshakes and registers the winner onto the write port with one cycle of latency.
- Sits between the execute/writeback stage and the register file's w_en/rd_addr/w_data inputs.

Parameters:
WIDTH, 32, data width of a register write.
N, 3, number of writeback requesters (2..8).
IDW, 2, width of grant_id; must satisfy 2^IDW >= N.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
hold  input  1  when 1, no grant is issued this cycle.
req_valid  input  N  per-requester write request valid.
req_ready  output  N  per-requester accept; combinational, one-hot or zero.
req_rd  input  N*5  destination register per requester; requester i uses bits [5i+4:5i].
req_data  input  N*WIDTH  write data per requester; requester i uses bits [WIDTH*i+WIDTH-1:WIDTH*i].
w_en  output  1  registered write enable to the register file.
rd_addr  output  5  registered destination address to the register file.
w_data  output  WIDTH  registered write data to the register file.
grant_id  output  IDW  registered index of the requester that produced the current w_en beat.

Behaviour:
- Reset (rst=1 at a clock edge): ptr=0, w_en=0, rd_addr=0, w_data=0, grant_id=0. req_ready is all-zero while rst=1.
- Arbitration is combinational each cycle. Candidates are the i with req_valid[i]=1.
- The winner is the first candidate found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
- req_ready[winner]=1 and all other bits are 0. If hold=1 or there are no candidates, req_ready is all zero.
- A transfer occurs when req_valid[i] and req_ready[i] are both 1.
- Requester i must hold valid, rd and data stable until its transfer.
- On a transfer from winner w at edge t:
  - w_en=1 at t+1, except w_en=0 when req_rd of w is 0 (x0 is never written; the request is still consumed).
  - rd_addr=req_rd[w], w_data=req_data[w], grant_id=w.
  - ptr <= (w+1) mod N.
- With no transfer: w_en <= 0, ptr unchanged. rd_addr, w_data and grant_id hold their last values.
- Throughput is one write per cycle. Latency from transfer to write-port beat is exactly 1 cycle.
- Fairness: with all N requesters continuously valid and hold=0, grants rotate 0,1,...,N-1,0,... Any continuously valid requester is granted within N cycles of hold deasserting.
- Duplicate rd across requesters in one cycle: only the winner is written. The others wait; no merging or cancellation.
- Reset mid-operation:
  - A pending registered beat is dropped (w_en=0 after reset).
  - Requesters not yet accepted must re-present their requests after reset.
- The write port has no backpressure, so no internal buffering beyond the single output register.
- Indices >= N never win. Arithmetic on ptr is mod N, not mod 2^IDW.

Test Plan:
- Reset: assert rst with req_valid all 1 -> req_ready=000, w_en=0, rd_addr=0, w_data=0, grant_id=0; next cycle after deassert, requester 0 granted.
- Single requester: only req_valid[1]=1, rd=5, data=0xDEADBEEF -> req_ready=010 same cycle; next cycle w_en=1, rd_addr=5, w_data=0xDEADBEEF, grant_id=1.
- Round-robin: all three valid for 6 cycles with distinct rd 1/2/3 -> grant_id sequence 0,1,2,0,1,2 and w_en=1 every cycle.
- x0 write: requester 2 valid with rd=0, data=0x1234 -> req_ready[2]=1, next cycle w_en=0, grant_id=2, ptr advances to 0.
- Hold: all valid, hold=1 for 3 cycles -> req_ready=000 and w_en=0 throughout; after release the grant resumes at the unchanged ptr.
- Reset mid-stream: transfer from requester 1 on cycle t, rst=1 on cycle t+1 -> w_en=0 after that edge, ptr=0, next grant goes to requester 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the single synchronous write port of the 2r1w integer register file
// among N writeback requesters (ALU, MUL, LSU, ...). Each cycle a round-robin
// arbiter picks one valid requester starting from a rotating pointer. The
// arbiter answers with a combinational one-hot ready and registers the
// winner's write onto the register-file port with exactly one cycle of latency.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   hold       : when 1, no grant is issued this cycle
//   req_valid  : [N]       per-requester write request valid
//   req_ready  : [N]       per-requester accept, combinational, one-hot or zero
//   req_rd     : [N*5]     destination register, requester i at [5i+4:5i]
//   req_data   : [N*WIDTH] write data, requester i at [WIDTH*i +: WIDTH]
//   w_en       : registered write enable (never set for destination x0)
//   rd_addr    : registered destination address
//   w_data     : registered write data
//   grant_id   : registered index of the requester behind the current beat
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*5-1:0]       req_rd,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic                 w_en,
  output logic [4:0]           rd_addr,
  output logic [WIDTH-1:0]     w_data,
  output logic [IDW-1:0]       grant_id
);

  // Index of the lowest set bit of a request mask (0 when the mask is empty).
  function automatic logic [IDW-1:0] lowest_idx(input logic [N-1:0] mask);
    logic [IDW-1:0] idx;
    idx = '0;
    // Scan downwards so the last hit written is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      idx = mask[i] ? IDW'(i) : idx;
    end
    return idx;
  endfunction

  // Round-robin pointer: the first index examined by the arbiter.
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;

  // Output register stage.
  logic             w_en_q;
  logic             w_en_d;
  logic [4:0]       rd_addr_q;
  logic [4:0]       rd_addr_d;
  logic [WIDTH-1:0] w_data_q;
  logic [WIDTH-1:0] w_data_d;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   grant_id_d;

  // Arbitration signals.
  logic [N-1:0]     hi_mask_s;
  logic [N-1:0]     lo_mask_s;
  logic [IDW-1:0]   win_idx_s;
  logic             grant_s;
  logic [N-1:0]     ready_s;
  logic [4:0]       sel_rd_s;
  logic [WIDTH-1:0] sel_data_s;

  // Split the candidates into the part at or after ptr and the wrapped part.
  // Taking the lowest index of the first non-empty part is exactly the scan
  // ptr, ptr+1, ..., N-1, 0, ..., ptr-1, and only indices < N can ever appear.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask_s[i] = req_valid[i] & (IDW'(i) >= ptr_q);
    end
    lo_mask_s = req_valid & ~hi_mask_s;
    win_idx_s = (|hi_mask_s) ? lowest_idx(hi_mask_s) : lowest_idx(lo_mask_s);
    grant_s   = ~rst & ~hold & (|req_valid);
  end

  // One-hot ready and the winner's rd/data, selected by AND-OR over the one-hot.
  always_comb begin
    ready_s    = '0;
    sel_rd_s   = 5'd0;
    sel_data_s = '0;
    for (int i = 0; i < N; i++) begin
      ready_s[i] = grant_s & (win_idx_s == IDW'(i));
      sel_rd_s   = sel_rd_s   | (req_rd[5*i +: 5]           & {5{ready_s[i]}});
      sel_data_s = sel_data_s | (req_data[WIDTH*i +: WIDTH] & {WIDTH{ready_s[i]}});
    end
  end

  // Next-state for the pointer and the output register stage.
  always_comb begin
    ptr_d      = ptr_q;
    w_en_d     = 1'b0;
    rd_addr_d  = rd_addr_q;
    w_data_d   = w_data_q;
    grant_id_d = grant_id_q;
    if (grant_s) begin
      // Pointer wraps mod N, not mod 2^IDW.
      ptr_d      = (win_idx_s == IDW'(N - 1)) ? '0 : win_idx_s + IDW'(1);
      // A write to x0 is still consumed but never enabled on the port.
      w_en_d     = (sel_rd_s != 5'd0);
      rd_addr_d  = sel_rd_s;
      w_data_d   = sel_data_s;
      grant_id_d = win_idx_s;
    end else begin
      ptr_d      = ptr_q;
      w_en_d     = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      w_en_q     <= 1'b0;
      rd_addr_q  <= 5'd0;
      w_data_q   <= '0;
      grant_id_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      w_en_q     <= w_en_d;
      rd_addr_q  <= rd_addr_d;
      w_data_q   <= w_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign req_ready = ready_s;
  assign w_en      = w_en_q;
  assign rd_addr   = rd_addr_q;
  assign w_data    = w_data_q;
  assign grant_id  = grant_id_q;

  rf_wb_arbiter_chk #(
    .N   (N),
    .IDW (IDW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_ready (ready_s),
    .w_en      (w_en_q),
    .rd_addr   (rd_addr_q),
    .ptr       (ptr_q)
  );

endmodule

// ---------------------------------------------------------------------------
// rf_wb_arbiter_chk
//
// Protocol properties of the arbiter, kept apart from the datapath.
// Ports: clk, rst, hold, req_ready [N], w_en, rd_addr [5], ptr [IDW].
// ---------------------------------------------------------------------------
module rf_wb_arbiter_chk #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  input  logic [N-1:0]   req_ready,
  input  logic           w_en,
  input  logic [4:0]     rd_addr,
  input  logic [IDW-1:0] ptr
);

  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));

  a_ready_blocked : assert property (@(posedge clk) (rst || hold) |-> (req_ready == '0));

  a_no_x0_write : assert property (@(posedge clk) disable iff (rst) w_en |-> (rd_addr != 5'd0));

  a_ptr_range : assert property (@(posedge clk) disable iff (rst) (int'(ptr) < N));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (N=3, WIDTH=32). The driver applies one
// vector per cycle, checks the combinational ready, and queues the expected
// register-port state after the edge; an independent monitor pops and compares.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        w_en;
  logic [4:0]  rd_addr;
  logic [31:0] w_data;
  logic [1:0]  grant_id;

  // Current per-requester destination/data configuration.
  logic [4:0]  r0, r1, r2;
  logic [31:0] d0, d1, d2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  id;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  rf_wb_arbiter #(.WIDTH(32), .N(3), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .w_en      (w_en),
    .rd_addr   (rd_addr),
    .w_data    (w_data),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: drive, check ready, queue the post-edge outputs.
  task automatic step(input logic r, input logic h, input logic [2:0] v,
                      input logic [2:0] er, input logic ew, input logic [4:0] erd,
                      input logic [31:0] ed, input logic [1:0] eid, input string name);
    exp_t e;
    rst       = r;
    hold      = h;
    req_valid = v;
    req_rd    = {r2, r1, r0};
    req_data  = {d2, d1, d0};
    #2;
    checks++;
    if (req_ready !== er) begin
      errors++;
      $display("FAIL %s ready: got %b expected %b", name, req_ready, er);
    end
    @(posedge clk);
    #1;
    e.wen  = ew;
    e.rd   = erd;
    e.data = ed;
    e.id   = eid;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the registered write port after every edge.
  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (w_en !== e.wen || rd_addr !== e.rd || w_data !== e.data || grant_id !== e.id) begin
        errors++;
        $display("FAIL %s port: got w_en=%b rd=%0d data=%h id=%0d expected w_en=%b rd=%0d data=%h id=%0d",
                 e.name, w_en, rd_addr, w_data, grant_id, e.wen, e.rd, e.data, e.id);
      end
    end else if (w_en === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat: got w_en=1 expected no beat");
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
    r0 = 5'd1; r1 = 5'd2; r2 = 5'd3;
    d0 = 32'hA0A0_0000; d1 = 32'hB1B1_0001; d2 = 32'hC2C2_0002;
    req_rd = {r2, r1, r0}; req_data = {d2, d1, d0};
    @(posedge clk);
    #1;

    // Reset with everyone valid.
    step(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0, "reset_a");
    step(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0, "reset_b");

    // Round-robin 0,1,2,0,1,2.
    step(1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 5'd1, d0, 2'd0, "rr0");
    step(1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 5'd2, d1, 2'd1, "rr1");
    step(1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 5'd3, d2, 2'd2, "rr2");
    step(1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 5'd1, d0, 2'd0, "rr3");
    step(1'b0, 1'b0, 3'b111, 3'b010, 1'b1, 5'd2, d1, 2'd1, "rr4");
    step(1'b0, 1'b0, 3'b111, 3'b100, 1'b1, 5'd3, d2, 2'd2, "rr5");

    // Hold for three cycles: no grants, outputs hold, ptr stays at 0.
    step(1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 5'd3, d2, 2'd2, "hold0");
    step(1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 5'd3, d2, 2'd2, "hold1");
    step(1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 5'd3, d2, 2'd2, "hold2");
    step(1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 5'd1, d0, 2'd0, "hold_release");

    // Single requester 1 (ptr=1).
    r1 = 5'd5; d1 = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1, "single1");
    // ptr=2, only requester 0 valid: scan wraps to 0.
    step(1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 5'd1, d0, 2'd0, "wrap_to0");

    // x0 write from requester 2 (ptr=1): consumed, no enable, ptr -> 0.
    r2 = 5'd0; d2 = 32'h0000_1234;
    step(1'b0, 1'b0, 3'b100, 3'b100, 1'b0, 5'd0, 32'h0000_1234, 2'd2, "x0_write");
    r2 = 5'd3; d2 = 32'hC2C2_0002;
    step(1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 5'd1, d0, 2'd0, "after_x0");

    // Idle cycle: nothing valid, port holds.
    step(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 5'd1, d0, 2'd0, "idle");

    // ptr=1 with requesters 0 and 2 valid: 2 wins.
    step(1'b0, 1'b0, 3'b101, 3'b100, 1'b1, 5'd3, d2, 2'd2, "skip_to2");
    // ptr=0 with requesters 1 and 2 valid: 1 wins.
    step(1'b0, 1'b0, 3'b110, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1, "skip_to1");

    // Duplicate rd=7 on requesters 0 and 2 (ptr=2): only 2 written, 0 waits.
    r0 = 5'd7; r2 = 5'd7;
    step(1'b0, 1'b0, 3'b101, 3'b100, 1'b1, 5'd7, d2, 2'd2, "dup_rd_a");
    step(1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 5'd7, d0, 2'd0, "dup_rd_b");

    // Reset mid-stream: transfer from 1, then reset drops state, 0 wins next.
    step(1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1, "mid_xfer");
    step(1'b1, 1'b0, 3'b111, 3'b000, 1'b0, 5'd0, 32'h0, 2'd0, "mid_reset");
    step(1'b0, 1'b0, 3'b111, 3'b001, 1'b1, 5'd7, d0, 2'd0, "post_reset");
    step(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 5'd7, d0, 2'd0, "final_idle");

    // Let the monitor drain the queue.
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
